// File: rtl/mac_accumulator_if.sv
// Handshake bundle for mac_accumulator: job control, product beats in, dot-product result out.
interface mac_accumulator_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             abort;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_ready;
  logic             busy;
  logic             ovf;

  modport master (
    output start, len, abort, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, ovf
  );

  modport slave (
    input  start, len, abort, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, ovf
  );
endinterface

// File: rtl/mac_accumulator.sv
// Multiply-accumulate sink: sums len signed 32-bit products into an ACC_W accumulator and returns one 32-bit result.
// Optional macro MAC_ACC_SAT_EN: saturate out_data on overflow instead of truncating.
module mac_accumulator #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_p,
  mac_accumulator_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0]        cnt;
  logic                    xfer, last;
  logic                    sum_ovf;
  logic [31:0]             sum_res;
  logic                    in_ready_nxt, out_valid_nxt;

  // Out of signed 32-bit range iff the bits from 31 upward are not all equal.
  function automatic logic is_ovf(input logic [ACC_W-32:0] hi);
    return !((&hi) || (~|hi));
  endfunction

  function automatic logic [31:0] saturate(input logic neg);
    return neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

  assign in_ext  = {{(ACC_W-32){bus.in_data[31]}}, bus.in_data};
  assign acc_sum = acc + in_ext;
  assign sum_ovf = is_ovf(acc_sum[ACC_W-1:31]);

`ifdef MAC_ACC_SAT_EN
  assign sum_res = sum_ovf ? saturate(acc_sum[ACC_W-1]) : acc_sum[31:0];
`else
  assign sum_res = acc_sum[31:0];
`endif

  // A beat presented together with abort is never taken.
  assign xfer = bus.in_valid & bus.in_ready & ~bus.abort;
  assign last = xfer && (cnt == CNT_W'(1));

  always_ff @(posedge clk_in or posedge rst_p) begin
    if (rst_p) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = (bus.len == '0) ? DONE : ACCUM;
      ACCUM:   if (last) state_nxt = DONE;
      DONE:    if (bus.out_valid & bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort) state_nxt = IDLE;
  end

  always_comb begin
    in_ready_nxt  = (state_nxt == ACCUM);
    out_valid_nxt = (state_nxt == DONE);
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk_in or posedge rst_p) begin
    if (rst_p) begin
      acc           <= '0;
      cnt           <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.ovf       <= 1'b0;
    end else begin
      bus.in_ready  <= in_ready_nxt;
      bus.out_valid <= out_valid_nxt;
      if (bus.abort) begin
        acc     <= '0;
        cnt     <= '0;
        bus.ovf <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (bus.start) begin
            acc <= '0;
            cnt <= bus.len;
            if (bus.len == '0) begin
              bus.out_data <= '0;
              bus.ovf      <= 1'b0;
            end
          end
          // Result is captured from the final sum so it is stable for the whole DONE phase.
          ACCUM: if (xfer) begin
            acc <= acc_sum;
            cnt <= cnt - 1'b1;
            if (last) begin
              bus.out_data <= sum_res;
              bus.ovf      <= sum_ovf;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: directed jobs push expected results, a monitor checks each result handshake.
module tb_mac_accumulator;

  logic clk_in = 1'b0;
  logic rst_p  = 1'b1;
  always #5 clk_in = ~clk_in;

  mac_accumulator_if #(.CNT_W(8)) bus ();

  mac_accumulator #(.ACC_W(40), .CNT_W(8)) dut (
    .clk_in (clk_in),
    .rst_p  (rst_p),
    .bus    (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   beats  = 0;
  int   b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_res(input logic [31:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    sb.push_back(e);
  endtask

  // Monitor: counts accepted beats and checks every result handshake against the scoreboard.
  always @(negedge clk_in) begin
    if (!rst_p) begin
      if (bus.in_valid && bus.in_ready && !bus.abort) beats++;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: actual out_data %0h with no result pending", bus.out_data);
        end else begin
          mon_e = sb.pop_front();
          chk("result_data", 64'(bus.out_data), 64'(mon_e.data));
          chk("result_ovf", 64'(bus.ovf), 64'(mon_e.ovf));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic start_job(input logic [7:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    idle(1);
    bus.start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 50) begin
      idle(1);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: in_ready %0b required 1", bus.in_ready);
    end else begin
      idle(1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 50) begin
      idle(1);
      n++;
    end
    chk(name, 64'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset values
    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 0);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_data", 64'(bus.out_data), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_ovf", 64'(bus.ovf), 0);
    rst_p = 1'b0;
    idle(1);

    // Basic sum 10 - 3 + 100 + 7 = 114, beats back to back
    bus.out_ready = 1'b1;
    expect_res(32'd114, 1'b0);
    b0 = beats;
    start_job(8'd4);
    chk("t1_in_ready_entry", 64'(bus.in_ready), 1);
    beat(32'd10);
    beat(32'hFFFF_FFFD);
    beat(32'd100);
    beat(32'd7);
    chk("t1_latency_out_valid", 64'(bus.out_valid), 1);
    chk("t1_in_ready_drop", 64'(bus.in_ready), 0);
    chk("t1_beats", 64'(beats - b0), 4);
    idle(1);
    chk("t1_busy_low", 64'(bus.busy), 0);
    chk("t1_out_valid_low", 64'(bus.out_valid), 0);

    // Gaps between beats and result backpressure: 0x1000 - 0x1000 + 5 = 5
    bus.out_ready = 1'b0;
    expect_res(32'd5, 1'b0);
    start_job(8'd3);
    beat(32'h0000_1000);
    idle(2);
    beat(32'hFFFF_F000);
    idle(2);
    beat(32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 64'(bus.out_valid), 1);
      chk("t2_hold_data", 64'(bus.out_data), 5);
      idle(1);
    end
    bus.out_ready = 1'b1;
    idle(1);
    chk("t2_out_valid_drop", 64'(bus.out_valid), 0);
    chk("t2_out_data_kept", 64'(bus.out_data), 5);

    // Positive and negative overflow past the signed 32-bit range
`ifdef MAC_ACC_SAT_EN
    expect_res(32'h7FFF_FFFF, 1'b1);
`else
    expect_res(32'h8000_000F, 1'b1);
`endif
    start_job(8'd2);
    beat(32'h7FFF_FFFF);
    beat(32'h0000_0010);
    wait_idle("t3_pos_idle");
`ifdef MAC_ACC_SAT_EN
    expect_res(32'h8000_0000, 1'b1);
`else
    expect_res(32'h7FFF_FFFF, 1'b1);
`endif
    start_job(8'd2);
    beat(32'h8000_0000);
    beat(32'hFFFF_FFFF);
    wait_idle("t3_neg_idle");

    // Zero-length job finishes immediately with a zero result
    expect_res(32'd0, 1'b0);
    b0 = beats;
    start_job(8'd0);
    chk("t4_zero_out_valid", 64'(bus.out_valid), 1);
    chk("t4_zero_in_ready", 64'(bus.in_ready), 0);
    wait_idle("t4_zero_idle");
    chk("t4_zero_beats", 64'(beats - b0), 0);

    // A start pulse while busy must not disturb the running job: 3 + 4 = 7
    expect_res(32'd7, 1'b0);
    b0 = beats;
    start_job(8'd2);
    beat(32'd3);
    start_job(8'd9);
    beat(32'd4);
    chk("t4_ignored_start_done", 64'(bus.out_valid), 1);
    wait_idle("t4_ignored_start_idle");
    chk("t4_ignored_start_beats", 64'(beats - b0), 2);

    // Abort after two beats with a beat presented in the abort cycle
    b0 = beats;
    start_job(8'd5);
    beat(32'd1);
    beat(32'd2);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd99;
    bus.abort    = 1'b1;
    idle(1);
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5_abort_busy", 64'(bus.busy), 0);
    chk("t5_abort_in_ready", 64'(bus.in_ready), 0);
    chk("t5_abort_out_valid", 64'(bus.out_valid), 0);
    chk("t5_abort_beats", 64'(beats - b0), 2);
    idle(3);
    chk("t5_abort_no_result", 64'(bus.out_valid), 0);
    expect_res(32'd42, 1'b0);
    start_job(8'd1);
    beat(32'd42);
    wait_idle("t5_after_abort_idle");

    // Asynchronous reset in the middle of a job
    start_job(8'd3);
    beat(32'd5);
    #3;
    rst_p = 1'b1;
    #1;
    chk("t6_rst_in_ready", 64'(bus.in_ready), 0);
    chk("t6_rst_busy", 64'(bus.busy), 0);
    chk("t6_rst_out_valid", 64'(bus.out_valid), 0);
    chk("t6_rst_out_data", 64'(bus.out_data), 0);
    chk("t6_rst_ovf", 64'(bus.ovf), 0);
    @(negedge clk_in);
    rst_p = 1'b0;
    idle(1);
    expect_res(32'd50, 1'b0);
    start_job(8'd2);
    beat(32'd100);
    beat(32'hFFFF_FFCE);
    wait_idle("t6_after_rst_idle");

    idle(2);
    chk("sb_drain", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
